// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths, FSM state type and address split for the icache tag controller
package icache_pkg;
    localparam int TAG_W = 18;
    localparam int IDX_W = 7;
    localparam int OFF_W = 7;
    localparam int WAYS  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_FILL_WR,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
    } addr_t;
endpackage

// File: rtl/icache_tag_ctrl_if.sv
// rtl/icache_tag_ctrl_if.sv - fetch, fill-engine and tag-RAM signals of the icache tag controller
interface icache_tag_ctrl_if;
    import icache_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [31:0]             req_addr;
    logic                    resp_valid;
    logic                    resp_hit;
    logic [1:0]              resp_way;
    logic                    flush;
    logic                    fill_req_valid;
    logic                    fill_req_ready;
    logic [31:0]             fill_req_addr;
    logic                    fill_done;
    logic [IDX_W-1:0]        tram_r_index;
    logic [WAYS*TAG_W-1:0]   tram_tag_out;
    logic [IDX_W+1:0]        tram_w_index;
    logic [TAG_W-1:0]        tram_tag_in;
    logic                    tram_wr_en;

    modport slave (
        input  req_valid, req_addr, flush, fill_req_ready, fill_done, tram_tag_out,
        output req_ready, resp_valid, resp_hit, resp_way, fill_req_valid, fill_req_addr,
               tram_r_index, tram_w_index, tram_tag_in, tram_wr_en
    );

    modport master (
        output req_valid, req_addr, flush, fill_req_ready, fill_done, tram_tag_out,
        input  req_ready, resp_valid, resp_hit, resp_way, fill_req_valid, fill_req_addr,
               tram_r_index, tram_w_index, tram_tag_in, tram_wr_en
    );
endinterface

// File: rtl/icache_plru.sv
// rtl/icache_plru.sv - 4-way victim select (invalid-first, else tree-PLRU) and PLRU update
module icache_plru
    import icache_pkg::*;
(
    input  logic [2:0]      plru_bits,
    input  logic [WAYS-1:0] valid,
    input  logic [1:0]      access_way,
    output logic [1:0]      victim,
    output logic [2:0]      plru_next
);

    always_comb begin
        victim = plru_bits[0] ? {1'b1, plru_bits[2]} : {1'b0, plru_bits[1]};
        // Descending scan so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = w[1:0];
            end
        end
    end

    always_comb begin
        plru_next    = plru_bits;
        plru_next[0] = ~access_way[1];
        if (!access_way[1]) begin
            plru_next[1] = ~access_way[0];
        end else begin
            plru_next[2] = ~access_way[0];
        end
    end

endmodule

// File: rtl/icache_tag_ctrl.sv
// rtl/icache_tag_ctrl.sv - icache tag lookup/fill sequencer; ICACHE_PERF_CNT_EN adds hit/miss counters
module icache_tag_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    icache_tag_ctrl_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        victim_q;
    logic              flush_pending_q;
    logic              resp_valid_q, resp_hit_q;
    logic [1:0]        resp_way_q;
    logic [31:0]       fill_addr_q;
    logic [WAYS-1:0]   valid_q [2**IDX_W];
    logic [2:0]        plru_q  [2**IDX_W];

    addr_t             req_a;
    logic [WAYS-1:0]   hit_vec;
    logic              hit_any;
    logic [1:0]        hit_way;
    logic [1:0]        access_way;
    logic [1:0]        victim;
    logic [2:0]        plru_next;

    assign req_a      = bus.req_addr;
    assign access_way = (state_q == S_FILL_WR) ? victim_q : hit_way;

    icache_plru u_plru (
        .plru_bits  (plru_q[idx_q]),
        .valid      (valid_q[idx_q]),
        .access_way (access_way),
        .victim     (victim),
        .plru_next  (plru_next)
    );

    always_comb begin
        hit_vec = '0;
        hit_way = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[idx_q][w] && (bus.tram_tag_out[w*TAG_W +: TAG_W] == tag_q);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = w[1:0];
            end
        end
        hit_any = |hit_vec;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.flush || flush_pending_q) begin
                    state_d = S_FLUSH;
                end else if (bus.req_valid) begin
                    state_d = S_RD;
                end
            end
            S_RD:        state_d = S_CMP;
            S_CMP:       state_d = hit_any ? S_IDLE : S_MISS_REQ;
            S_MISS_REQ:  if (bus.fill_req_ready) state_d = S_MISS_WAIT;
            S_MISS_WAIT: if (bus.fill_done) state_d = S_FILL_WR;
            S_FILL_WR:   state_d = S_IDLE;
            S_FLUSH:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // A same-cycle flush also drops req_ready so a request is never silently lost.
    assign bus.req_ready      = (state_q == S_IDLE) && !flush_pending_q && !bus.flush;
    assign bus.tram_r_index   = (state_q == S_IDLE) ? req_a.index : idx_q;
    assign bus.fill_req_valid = (state_q == S_MISS_REQ);
    assign bus.fill_req_addr  = fill_addr_q;
    assign bus.tram_wr_en     = (state_q == S_FILL_WR);
    assign bus.tram_w_index   = (state_q == S_FILL_WR) ? {idx_q, victim_q} : '0;
    assign bus.tram_tag_in    = (state_q == S_FILL_WR) ? tag_q : '0;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_hit       = resp_hit_q;
    assign bus.resp_way       = resp_way_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            tag_q           <= '0;
            idx_q           <= '0;
            victim_q        <= '0;
            flush_pending_q <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_way_q      <= '0;
            fill_addr_q     <= '0;
            for (int s = 0; s < 2**IDX_W; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            if (bus.flush && state_q != S_IDLE) begin
                flush_pending_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_RD) begin
                        tag_q <= req_a.tag;
                        idx_q <= req_a.index;
                    end
                end
                S_CMP: begin
                    if (hit_any) begin
                        resp_valid_q  <= 1'b1;
                        resp_hit_q    <= 1'b1;
                        resp_way_q    <= hit_way;
                        plru_q[idx_q] <= plru_next;
                    end else begin
                        victim_q    <= victim;
                        fill_addr_q <= {tag_q, idx_q, {OFF_W{1'b0}}};
                    end
                end
                S_FILL_WR: begin
                    valid_q[idx_q][victim_q] <= 1'b1;
                    plru_q[idx_q]            <= plru_next;
                    resp_valid_q             <= 1'b1;
                    resp_hit_q               <= 1'b0;
                    resp_way_q               <= victim_q;
                end
                S_FLUSH: begin
                    for (int s = 0; s < 2**IDX_W; s++) begin
                        valid_q[s] <= '0;
                        plru_q[s]  <= '0;
                    end
                    flush_pending_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (resp_valid_q) begin
            if (resp_hit_q && perf_hits != 32'hFFFF_FFFF) begin
                perf_hits <= perf_hits + 32'd1;
            end
            if (!resp_hit_q && perf_misses != 32'hFFFF_FFFF) begin
                perf_misses <= perf_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb/tb_icache_tag_ctrl.sv - scoreboard bench for icache_tag_ctrl with a behavioural tag RAM
module tb_icache_tag_ctrl;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_tag_ctrl_if bus ();
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    icache_tag_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    logic [TAG_W-1:0] tmem [128][4];
    always @(posedge clk) begin
        bus.tram_tag_out <= {tmem[bus.tram_r_index][3], tmem[bus.tram_r_index][2],
                             tmem[bus.tram_r_index][1], tmem[bus.tram_r_index][0]};
        if (bus.tram_wr_en) begin
            tmem[bus.tram_w_index[8:2]][bus.tram_w_index[1:0]] <= bus.tram_tag_in;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {logic hit; logic [1:0] way;} resp_t;
    typedef struct packed {logic [8:0] idx; logic [17:0] tag;} wr_t;
    resp_t exp_resp[$];
    wr_t   exp_wr[$];

    always @(negedge clk) begin : monitor
        resp_t r;
        wr_t   w;
        if (!rst) begin
            if (bus.resp_valid) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_hit", bus.resp_hit, r.hit);
                    chk("resp_way", bus.resp_way, r.way);
                end
            end
            if (bus.tram_wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("tram_wr_unexpected", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("tram_w_index", bus.tram_w_index, w.idx);
                    chk("tram_tag_in", bus.tram_tag_in, w.tag);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a);
        int n;
        n = 0;
        bus.req_addr  = a;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_accept_timeout", n < 50, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_fill_req();
        int n;
        n = 0;
        while (!bus.fill_req_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("fill_req_timeout", n < 20, 1);
    endtask

    task automatic hit_req(input logic [31:0] a, input logic [1:0] way);
        exp_resp.push_back('{1'b1, way});
        do_req(a);
        chk("hit_no_fill_e0", bus.fill_req_valid, 0);
        @(posedge clk); #1;
        chk("hit_lat_e1", bus.resp_valid, 0);
        @(posedge clk); #1;
        chk("hit_lat_e2", bus.resp_valid, 1);
        chk("hit_no_fill_e2", bus.fill_req_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic miss_req(input logic [31:0] a, input logic [1:0] way,
                            input int bp_cycles, input bit stray, input bit flush_wait);
        logic [31:0] line;
        line = {a[31:7], 7'h00};
        exp_resp.push_back('{1'b0, way});
        exp_wr.push_back('{{a[13:7], way}, a[31:14]});
        do_req(a);
        wait_fill_req();
        chk("fill_req_addr", bus.fill_req_addr, line);
        for (int i = 0; i < bp_cycles; i++) begin
            bus.fill_done = stray && (i == 3);
            @(posedge clk); #1;
            bus.fill_done = 1'b0;
            chk("bp_fill_valid", bus.fill_req_valid, 1);
            chk("bp_fill_addr", bus.fill_req_addr, line);
            chk("bp_req_ready", bus.req_ready, 0);
        end
        bus.fill_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.fill_req_ready = 1'b0;
        chk("fill_req_dropped", bus.fill_req_valid, 0);
        if (flush_wait) begin
            bus.flush = 1'b1;
            @(posedge clk); #1;
            bus.flush = 1'b0;
            chk("flush_wait_req_ready", bus.req_ready, 0);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("no_write_before_done", bus.tram_wr_en, 0);
        bus.fill_done = 1'b1;
        @(posedge clk); #1;
        bus.fill_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 128; s++) begin
            for (int w = 0; w < 4; w++) begin
                tmem[s][w] = '0;
            end
        end
        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_addr       = 32'h0000_0380;
        bus.flush          = 1'b0;
        bus.fill_req_ready = 1'b0;
        bus.fill_done      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_fill_req_valid", bus.fill_req_valid, 0);
        chk("rst_tram_wr_en", bus.tram_wr_en, 0);
        chk("rst_fill_req_addr", bus.fill_req_addr, 0);
        chk("rst_tram_w_index", bus.tram_w_index, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("idle_r_index", bus.tram_r_index, 7);

        miss_req(32'h0000_4080, 2'd0, 0, 1'b0, 1'b0);
        hit_req (32'h0000_40C4, 2'd0);
        miss_req(32'h0000_8080, 2'd1, 10, 1'b1, 1'b0);
        miss_req(32'h0000_C080, 2'd2, 0, 1'b0, 1'b0);
        miss_req(32'h0001_0080, 2'd3, 0, 1'b0, 1'b0);
        miss_req(32'h0001_4080, 2'd0, 0, 1'b0, 1'b0);
        hit_req (32'h0001_4080, 2'd0);
        miss_req(32'h0001_8080, 2'd2, 0, 1'b0, 1'b0);
        hit_req (32'h0000_8084, 2'd1);

        miss_req(32'h0000_0100, 2'd0, 0, 1'b0, 1'b1);
        miss_req(32'h0000_0100, 2'd0, 0, 1'b0, 1'b0);
        miss_req(32'h0000_40C4, 2'd0, 0, 1'b0, 1'b0);

        do_req(32'h0002_0300);
        wait_fill_req();
        bus.fill_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.fill_req_ready = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("amid_resp_valid", bus.resp_valid, 0);
        chk("amid_resp_hit", bus.resp_hit, 0);
        chk("amid_resp_way", bus.resp_way, 0);
        chk("amid_fill_req_valid", bus.fill_req_valid, 0);
        chk("amid_fill_req_addr", bus.fill_req_addr, 0);
        chk("amid_tram_wr_en", bus.tram_wr_en, 0);
        chk("amid_tram_w_index", bus.tram_w_index, 0);
        chk("amid_tram_tag_in", bus.tram_tag_in, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        miss_req(32'h0002_0300, 2'd0, 0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("resp_queue_drained", exp_resp.size(), 0);
        chk("wr_queue_drained", exp_wr.size(), 0);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hits", perf_hits, 0);
        chk("perf_misses", perf_misses, 1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_tag_ctrl.md
Name: icache_tag_ctrl

Overview:
Lookup/fill sequencer for the 4-way instruction-cache tag array (128 sets x 4 ways x 18-bit tags, synchronous-read block RAM). Accepts one fetch lookup at a time, reads all 4 tags of the set, compares them against per-way valid bits held in this block, and reports hit/way. On a miss it picks a victim (invalid-first, else tree-PLRU), requests the line fill, and writes the new tag. Sits between the fetch stage and the tag RAM and line-fill engine.

Parameters:
TAG_W, 18, tag bits per way
IDX_W, 7, set index bits (128 sets)
OFF_W, 7, line offset bits (128 B lines); address = {tag, index, offset}, 32 bits total

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
req_valid  in  1  lookup request
req_ready  out  1  high only in IDLE with no flush pending
req_addr  in  32  fetch byte address
resp_valid  out  1  one-cycle pulse per accepted request
resp_hit  out  1  1 = tag hit, 0 = served by fill
resp_way  out  2  hit or filled way
flush  in  1  invalidate-all pulse
fill_req_valid  out  1  line fill request
fill_req_ready  in  1  fill engine accepts
fill_req_addr  out  32  line-aligned miss address (offset bits zero)
fill_done  in  1  one-cycle pulse, line data written
tram_r_index  out  7  tag RAM read set
tram_tag_out  in  72  4 tags, way w at [18w+17:18w]
tram_w_index  out  9  {set, way}
tram_tag_in  out  18  tag to write
tram_wr_en  out  1  tag RAM write enable

Behaviour:
- Reset: state IDLE; all valid bits 0, all PLRU bits 0; resp_valid, resp_hit, resp_way, fill_req_valid, tram_wr_en = 0; fill_req_addr, tram_w_index, tram_tag_in = 0; flush_pending = 0. Reset mid-miss abandons the fill without writing a tag.
- tram_r_index = req_addr index bits, combinationally, in IDLE; otherwise the captured index.
- States: IDLE, RD, CMP, MISS_REQ, MISS_WAIT, FILL_WR, FLUSH.
- IDLE: flush or flush_pending -> FLUSH (priority over req). Else req_valid && req_ready -> capture tag/index, go to RD.
- RD: one cycle; the RAM registers the index. -> CMP.
- CMP: tram_tag_out valid. hit_w = valid[idx][w] && tag_w == captured tag. Any hit -> register resp_valid=1, resp_hit=1, resp_way = lowest hitting way; update PLRU; -> IDLE. Hit latency: resp_valid is high 2 cycles after the acceptance edge. Miss -> latch victim and fill_req_addr; -> MISS_REQ.
- Victim: lowest-numbered invalid way, else PLRU victim.
- PLRU (3 bits per set): b0=0 -> victim in ways 0/1, else ways 2/3; b1 selects within 0/1 (0 -> way0); b2 selects within 2/3 (0 -> way2). On access to way w: b0 = (w<2); if w<2 then b1 = (w==0), else b2 = (w==2).
- MISS_REQ: fill_req_valid=1, held stable until fill_req_ready. On the handshake -> MISS_WAIT.
- MISS_WAIT: wait for fill_done. A fill_done seen in MISS_REQ is ignored.
- FILL_WR: tram_wr_en=1 for one cycle, tram_w_index = {idx, victim}, tram_tag_in = tag. Set the valid bit and update PLRU. Register resp_valid=1, resp_hit=0, resp_way=victim. -> IDLE.
- FLUSH: clear all valid and PLRU bits in one cycle, clear flush_pending. -> IDLE.
- flush asserted outside IDLE: set flush_pending. An in-flight miss still completes, then the flush is applied.
- A lookup following a fill to the same set sees the new tag, because the RAM write completes before the next RD.

Optional Feature:
Macro ICACHE_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_hits and perf_misses. Each increments on a resp_valid with the matching resp_hit value, saturates at 0xFFFFFFFF, and is cleared only by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package icache_pkg: TAG_W, IDX_W, OFF_W, WAYS=4, the state enum type, and an address-split struct {tag, index, offset}.
- Sub-module icache_plru: combinational victim select from 3 PLRU bits plus a 4-bit valid vector, and the PLRU next-state function for an accessed way. The PLRU/valid storage stays in icache_tag_ctrl.

Test Plan:
- Cold miss: after reset, req 0x0000_4080 (set 1) -> fill_req_addr 0x0000_4080. Ack, then fill_done -> tram_wr_en with w_index {1, way0}, tag_in 0x00001; resp_hit=0, resp_way=0.
- Hit: repeat 0x0000_40C4 -> resp_valid 2 cycles after accept, resp_hit=1, resp_way=0, no fill_req.
- Replacement: fill 5 distinct tags into set 1 -> ways 0,1,2,3 filled in order; 5th victim = way0. Then hit way0 and fill a 6th tag -> victim way2.
- Flush during miss: assert flush in MISS_WAIT -> fill write occurs, then FLUSH. The next req to the same address misses.
- Fill backpressure: hold fill_req_ready=0 for 10 cycles -> fill_req_valid and fill_req_addr stay stable and req_ready stays 0; stray fill_done in MISS_REQ is ignored.
- Async reset asserted in MISS_WAIT -> all outputs 0 immediately; a later req to the same address misses.
